conta_votos: RTL and testbench
==============================

Name: conta_votos

Overview:
- Synchronous vote counter for a small panel of voters.
- Each cycle it samples a vector of yes/no votes and drives a registered one-hot result: R[k] is set when exactly k votes are 1.
- It also keeps a saturating running total of yes-votes over enabled cycles.
- Sits between voter input logic (switches/debounced buttons) and display/decision logic.

Parameters:
- N_VOTERS, 3, number of voters; width of V; R is N_VOTERS+1 bits.
- TOT_W, 8, width of the running yes-vote total accumulator.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; V is captured only when en=1.
- V  input  N_VOTERS  vote vector, bit i = 1 means voter i votes yes.
- R  output  N_VOTERS+1  registered one-hot count of yes-votes.
- total  output  TOT_W  saturating sum of yes-votes over all enabled samples.
- maj  output  1  only with CONTA_VOTOS_MAJORITY_EN; registered strict majority flag.

Behaviour:
- One clock, one reset. Reset is asynchronous and active-high.
- Reset values:
  - R = one-hot for zero votes (R[0]=1, all other bits 0; for N_VOTERS=3, R=4'b0001).
  - total = 0.
  - maj = 0.
- Count: cnt = popcount(V), range 0..N_VOTERS, computed combinationally.
- R update: on a rising clk edge with en=1, R <= one-hot(cnt), i.e. R[cnt]=1 and all other bits 0.
  - Latency is 1 cycle from V sampled to R valid.
  - R is always exactly one-hot after reset, never all-zero or multi-hot.
- Hold: with en=0, R, total and maj hold their values; V is ignored.
- Total: on an edge with en=1, total <= min(total + cnt, 2^TOT_W - 1).
  - Saturates at all-ones and never wraps.
  - Once saturated it stays saturated until reset.
- Reset mid-operation: asserting rst at any time immediately forces the reset values, independent of clk.
  - The first edge after rst deasserts with en=1 samples normally.
- Required mapping for N_VOTERS=3 (V -> R after one enabled edge):
  - 000 -> 0001
  - 001, 010, 100 -> 0010
  - 011, 101, 110 -> 0100
  - 111 -> 1000
- No X propagation: outputs are defined from reset onward.

Optional Feature:
- Macro: CONTA_VOTOS_MAJORITY_EN.
- Defined:
  - Port maj exists.
  - On an enabled edge, maj <= (2*cnt > N_VOTERS); it updates together with R.
  - maj holds when en=0 and resets to 0.
- Not defined:
  - Port maj and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package conta_votos_pkg holds:
  - default constants N_VOTERS_DEF=3 and TOT_W_DEF=8;
  - function popcount(V);
  - function onehot_of(count, width).
- One natural sub-module: conta_votos_popcnt, the combinational adder tree giving cnt from V, width $clog2(N_VOTERS+1).
- The top module holds the R, total and maj registers and the saturation logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> R=0001, total=0, maj=0 immediately, without waiting for a clk edge.
- Exhaustive sweep: en=1, V = 000, 001, 010, 011, 100, 101, 110, 111 on consecutive cycles -> one cycle later each, R = 0001, 0010, 0010, 0100, 0010, 0100, 0100, 1000; total ends at 12.
- Hold: V=111 with en=1 for one cycle, then V=000 with en=0 for 5 cycles -> R stays 1000 and total stays 3.
- Saturation: TOT_W=4, V=111, en=1 for 6 cycles -> total = 3, 6, 9, 12, 15, 15.
- Majority (macro defined): V=011 -> maj=1; V=100 -> maj=0; V=111 -> maj=1; each registered with 1-cycle latency.
- Reset recovery: V=110 with en=1, rst pulse, then the next enabled edge with V=001 -> R=0010, total=1.

Source files
------------

// File: rtl/conta_votos_pkg.sv
// Shared constants and helpers for the conta_votos vote counter.
// Used by conta_votos (top) and conta_votos_popcnt.
package conta_votos_pkg;

    localparam int N_VOTERS_DEF = 3;
    localparam int TOT_W_DEF    = 8;

    // Widest vote vector / one-hot result the helper functions handle
    localparam int MAX_W = 32;

    function automatic int popcount(input logic [MAX_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

    // One-hot vector with bit 'count' set; all-zero if count is outside 0..width-1
    function automatic logic [MAX_W:0] onehot_of(input int count, input int width);
        logic [MAX_W:0] r;
        r = '0;
        if (count >= 0 && count < width) begin
            r = (MAX_W + 1)'(1) << count;
        end
        return r;
    endfunction

endpackage

// File: rtl/conta_votos_popcnt.sv
// Combinational yes-vote counter: cnt = number of set bits in v.
// Built as a chain of small adders, one stage per voter.
module conta_votos_popcnt
    import conta_votos_pkg::*;
#(
    parameter int N_VOTERS = N_VOTERS_DEF,
    parameter int CW       = $clog2(N_VOTERS_DEF + 1)
) (
    input  logic [N_VOTERS-1:0] v,
    output logic [CW-1:0]       cnt
);

    // part[k] holds the number of yes-votes among v[k-1:0]
    logic [CW-1:0] part [N_VOTERS+1];

    assign part[0] = '0;

    generate
        for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_stage
            assign part[gi+1] = part[gi] + CW'(v[gi]);
        end
    endgenerate

    assign cnt = part[N_VOTERS];

endmodule

// File: rtl/conta_votos.sv
// Vote counter: registered one-hot yes-count R and saturating running total.
// Optional macro CONTA_VOTOS_MAJORITY_EN adds the registered strict-majority flag maj.
module conta_votos
    import conta_votos_pkg::*;
#(
    parameter int N_VOTERS = N_VOTERS_DEF,
    parameter int TOT_W    = TOT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_VOTERS-1:0] V,
    output logic [N_VOTERS:0]   R,
`ifdef CONTA_VOTOS_MAJORITY_EN
    output logic [TOT_W-1:0]    total,
    output logic                maj
`else
    output logic [TOT_W-1:0]    total
`endif
);

    localparam int CW = $clog2(N_VOTERS + 1);
    // Sum wide enough that total + cnt can never wrap before the saturation check
    localparam int SW = TOT_W + CW + 1;

    localparam logic [N_VOTERS:0] R_RST   = {{N_VOTERS{1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0]  TOT_MAX = '1;

    logic [CW-1:0]      cnt;
    logic [N_VOTERS:0]  r_d, r_q;
    logic [TOT_W-1:0]   total_d, total_q;
    logic [SW-1:0]      sum;
    logic [MAX_W:0]     onehot;

    conta_votos_popcnt #(
        .N_VOTERS (N_VOTERS),
        .CW       (CW)
    ) u_popcnt (
        .v   (V),
        .cnt (cnt)
    );

    always_comb begin
        r_d     = r_q;
        total_d = total_q;
        onehot  = onehot_of(int'(cnt), N_VOTERS + 1);
        sum     = SW'(total_q) + SW'(cnt);
        if (en) begin
            r_d     = onehot[N_VOTERS:0];
            total_d = (sum > SW'(TOT_MAX)) ? TOT_MAX : sum[TOT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= R_RST;
            total_q <= '0;
        end else begin
            r_q     <= r_d;
            total_q <= total_d;
        end
    end

    assign R     = r_q;
    assign total = total_q;

`ifdef CONTA_VOTOS_MAJORITY_EN
    logic maj_d, maj_q;

    // Strict majority: 2*cnt > N_VOTERS, evaluated without a multiplier
    always_comb begin
        maj_d = maj_q;
        if (en) begin
            maj_d = ({cnt, 1'b0} > (CW + 1)'(N_VOTERS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj_q <= 1'b0;
        end else begin
            maj_q <= maj_d;
        end
    end

    assign maj = maj_q;
`endif

endmodule

// File: tb/tb_conta_votos.sv
// Self-checking bench for conta_votos: directed scenarios plus randomized traffic
// against an arithmetic reference model; a TOT_W=4 instance covers saturation.
module tb_conta_votos;

    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] V;

    logic [N:0]   r_a, r_b;
    logic [7:0]   total_a;
    logic [3:0]   total_b;
`ifdef CONTA_VOTOS_MAJORITY_EN
    logic         maj_a, maj_b;
`endif

    conta_votos #(.N_VOTERS(N), .TOT_W(8)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .V     (V),
        .R     (r_a),
`ifdef CONTA_VOTOS_MAJORITY_EN
        .total (total_a),
        .maj   (maj_a)
`else
        .total (total_a)
`endif
    );

    conta_votos #(.N_VOTERS(N), .TOT_W(4)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .V     (V),
        .R     (r_b),
`ifdef CONTA_VOTOS_MAJORITY_EN
        .total (total_b),
        .maj   (maj_b)
`else
        .total (total_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_cnt;
    int m_tot8;
    int m_tot4;
    int m_r;
    int m_maj;

    task automatic model_reset();
        m_r    = 1;
        m_tot8 = 0;
        m_tot4 = 0;
        m_maj  = 0;
    endtask

    // Drive one cycle of inputs, clock it, and advance the model
    task automatic step(input logic [N-1:0] v_in, input logic en_in);
        V  = v_in;
        en = en_in;
        @(posedge clk);
        #1;
        if (en_in) begin
            m_cnt  = $countones(v_in);
            m_r    = 1 << m_cnt;
            m_tot8 = (m_tot8 + m_cnt > 255) ? 255 : m_tot8 + m_cnt;
            m_tot4 = (m_tot4 + m_cnt > 15) ? 15 : m_tot4 + m_cnt;
            m_maj  = (2 * m_cnt > N) ? 1 : 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #4;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        step(3'b111, 1'b1);
        step(3'b011, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (r_a !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_R actual=%b required=0001", r_a);
        end
        n_cmp++;
        if (total_a !== 8'd0) begin
            n_err++;
            $display("FAIL reset_total actual=%0d required=0", total_a);
        end
`ifdef CONTA_VOTOS_MAJORITY_EN
        n_cmp++;
        if (maj_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_maj actual=%b required=0", maj_a);
        end
`endif
        $display("reset: R=%b total=%0d", r_a, total_a);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sweep();
        logic [N:0] exp_tbl [8];
        exp_tbl = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(3'(i), 1'b1);
            n_cmp++;
            if (r_a !== exp_tbl[i]) begin
                n_err++;
                $display("FAIL sweep_R V=%b actual=%b required=%b", 3'(i), r_a, exp_tbl[i]);
            end
            $display("sweep: V=%b R=%b total=%0d", 3'(i), r_a, total_a);
        end
        n_cmp++;
        if (total_a !== 8'd12) begin
            n_err++;
            $display("FAIL sweep_total actual=%0d required=12", total_a);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(3'b111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(3'b000, 1'b0);
            n_cmp++;
            if (r_a !== 4'b1000 || total_a !== 8'd3) begin
                n_err++;
                $display("FAIL hold cycle=%0d actual R=%b total=%0d required R=1000 total=3", i, r_a, total_a);
            end
`ifdef CONTA_VOTOS_MAJORITY_EN
            n_cmp++;
            if (maj_a !== 1'b1) begin
                n_err++;
                $display("FAIL hold_maj cycle=%0d actual=%b required=1", i, maj_a);
            end
`endif
            $display("hold: cycle=%0d R=%b total=%0d", i, r_a, total_a);
        end
    endtask

    task automatic test_saturation();
        int exp_sat [6];
        exp_sat = '{3, 6, 9, 12, 15, 15};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b1);
            n_cmp++;
            if (int'(total_b) != exp_sat[i]) begin
                n_err++;
                $display("FAIL sat_total4 cycle=%0d actual=%0d required=%0d", i, total_b, exp_sat[i]);
            end
            $display("saturation: cycle=%0d total4=%0d", i, total_b);
        end
    endtask

`ifdef CONTA_VOTOS_MAJORITY_EN
    task automatic test_majority();
        logic [N-1:0] vv [3];
        logic         mm [3];
        vv = '{3'b011, 3'b100, 3'b111};
        mm = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(vv[i], 1'b1);
            n_cmp++;
            if (maj_a !== mm[i]) begin
                n_err++;
                $display("FAIL majority V=%b actual=%b required=%b", vv[i], maj_a, mm[i]);
            end
            $display("majority: V=%b maj=%b", vv[i], maj_a);
        end
    endtask
`endif

    task automatic test_reset_recovery();
        do_reset();
        step(3'b110, 1'b1);
        do_reset();
        step(3'b001, 1'b1);
        n_cmp++;
        if (r_a !== 4'b0010 || total_a !== 8'd1) begin
            n_err++;
            $display("FAIL recovery actual R=%b total=%0d required R=0010 total=1", r_a, total_a);
        end
        $display("recovery: R=%b total=%0d", r_a, total_a);
    endtask

    task automatic test_random();
        logic [N-1:0] vr;
        logic         er;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            vr = 3'($urandom_range(0, 7));
            er = ($urandom_range(0, 3) != 0);
            step(vr, er);
            n_cmp++;
            if (int'(r_a) != m_r || int'(total_a) != m_tot8 || int'(total_b) != m_tot4 || r_b !== r_a) begin
                n_err++;
                $display("FAIL random i=%0d V=%b en=%b actual R=%b total8=%0d total4=%0d required R=%0d total8=%0d total4=%0d",
                         i, vr, er, r_a, total_a, total_b, m_r, m_tot8, m_tot4);
            end
`ifdef CONTA_VOTOS_MAJORITY_EN
            n_cmp++;
            if (int'(maj_a) != m_maj) begin
                n_err++;
                $display("FAIL random_maj i=%0d actual=%b required=%0d", i, maj_a, m_maj);
            end
`endif
            $display("random: i=%0d V=%b en=%b R=%b total8=%0d total4=%0d", i, vr, er, r_a, total_a, total_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        V   = '0;
        model_reset();
        #12;
        n_cmp++;
        if (r_a !== 4'b0001 || total_a !== 8'd0 || total_b !== 4'd0) begin
            n_err++;
            $display("FAIL power_on_reset actual R=%b total=%0d required R=0001 total=0", r_a, total_a);
        end
        #1;
        rst = 1'b0;

        test_reset();
        test_sweep();
        test_hold();
        test_saturation();
`ifdef CONTA_VOTOS_MAJORITY_EN
        test_majority();
`endif
        test_reset_recovery();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
